// File: rtl/seq_serializer.sv
// Purpose : parallel-to-serial feeder for the sequence detector; one bit per clock.
// Latency : first bit on o_seq one cycle after the handshake edge; BW_DATA bits back to back.
// Backpr. : o_ready only in IDLE or on the last bit; a held i_valid reloads with no bubble.
//
// Ports:
//   i_clk, i_rstn             clock, synchronous active-low reset
//   i_data, i_valid, o_ready  parallel word in, valid/ready handshake
//   o_seq, o_seq_vld          serial bit and its qualifier (registered, o_seq=0 when idle)
//   o_busy                    high while shifting (registered)
//   o_word_done               marks the cycle carrying the last bit of a word
module seq_serializer #(
  parameter int BW_DATA   = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [BW_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_seq,
  output logic               o_seq_vld,
  output logic               o_busy,
  output logic               o_word_done
);

  localparam int               CNT_W    = $clog2(BW_DATA);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BW_DATA - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BW_DATA-1:0] sreg;

  logic at_last;
  logic xfer;
  logic first_bit;
  logic next_bit;

  // The bit currently on o_seq always sits at the outgoing end of sreg,
  // so the next bit to send is its neighbour.
  assign at_last     = (state == SHIFT) && (cnt == CNT_LAST);
  assign o_ready     = (state == IDLE) || at_last;
  assign xfer        = i_valid && o_ready;
  assign o_word_done = o_seq_vld && (cnt == CNT_LAST);
  assign first_bit   = MSB_FIRST ? i_data[BW_DATA-1] : i_data[0];
  assign next_bit    = MSB_FIRST ? sreg[BW_DATA-2] : sreg[1];

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      o_seq     <= 1'b0;
      o_seq_vld <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            state     <= SHIFT;
            cnt       <= '0;
            sreg      <= i_data;
            o_seq     <= first_bit;
            o_seq_vld <= 1'b1;
            o_busy    <= 1'b1;
          end else begin
            o_seq     <= 1'b0;
            o_seq_vld <= 1'b0;
            o_busy    <= 1'b0;
          end
        end

        SHIFT: begin
          if (cnt != CNT_LAST) begin
            cnt   <= cnt + CNT_W'(1);
            sreg  <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
            o_seq <= next_bit;
          end else if (xfer) begin
            // Reload on the last bit so consecutive words abut without a gap.
            cnt   <= '0;
            sreg  <= i_data;
            o_seq <= first_bit;
          end else begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            o_seq     <= 1'b0;
            o_seq_vld <= 1'b0;
            o_busy    <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          sreg      <= '0;
          o_seq     <= 1'b0;
          o_seq_vld <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
module tb_seq_serializer;

  localparam int BW = 8;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_rstn  = 1'b0;
  logic          i_valid = 1'b0;
  logic [BW-1:0] i_data  = '0;

  logic m_ready, m_seq, m_vld, m_busy, m_done;
  logic l_ready, l_seq, l_vld, l_busy, l_done;

  seq_serializer #(.BW_DATA(BW), .MSB_FIRST(1'b1)) dut_m (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_data(i_data), .i_valid(i_valid),
    .o_ready(m_ready), .o_seq(m_seq), .o_seq_vld(m_vld), .o_busy(m_busy),
    .o_word_done(m_done)
  );

  seq_serializer #(.BW_DATA(BW), .MSB_FIRST(1'b0)) dut_l (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_data(i_data), .i_valid(i_valid),
    .o_ready(l_ready), .o_seq(l_seq), .o_seq_vld(l_vld), .o_busy(l_busy),
    .o_word_done(l_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: number of bits still to appear (including the one on
  // the line now) and the word they come from.
  int            rem = 0;
  logic [BW-1:0] cur_word = '0;
  bit            last_xfer = 1'b0;

  // Reassembly of the serial streams in the random phase.
  bit            rec_en = 1'b0;
  logic [BW-1:0] sent_q[$];
  logic [BW-1:0] exp_w;
  logic [BW-1:0] acc_m = '0, acc_l = '0;
  int            n_m = 0, n_l = 0, done_m = 0, done_l = 0, words_m = 0, words_l = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_bit(input bit msb);
    int idx;
    if (rem == 0) return 1'b0;
    idx = BW - rem;
    return msb ? cur_word[BW-1-idx] : cur_word[idx];
  endfunction

  task automatic model_update();
    last_xfer = 1'b0;
    if (!i_rstn) begin
      rem = 0;
    end else begin
      last_xfer = i_valid && (rem <= 1);
      if (last_xfer) begin
        cur_word = i_data;
        rem      = BW;
      end else if (rem > 0) begin
        rem--;
      end
    end
  endtask

  task automatic check_model();
    chk("m_ready", m_ready, rem <= 1);
    chk("m_vld",   m_vld,   rem > 0);
    chk("m_busy",  m_busy,  rem > 0);
    chk("m_done",  m_done,  rem == 1);
    chk("m_seq",   m_seq,   exp_bit(1'b1));
    chk("l_ready", l_ready, rem <= 1);
    chk("l_vld",   l_vld,   rem > 0);
    chk("l_busy",  l_busy,  rem > 0);
    chk("l_done",  l_done,  rem == 1);
    chk("l_seq",   l_seq,   exp_bit(1'b0));
  endtask

  task automatic reassemble();
    if (m_done) done_m++;
    if (l_done) done_l++;
    if (m_vld) begin
      acc_m = {acc_m[BW-2:0], m_seq};
      n_m++;
      if (n_m == BW) begin
        n_m = 0;
        exp_w = (sent_q.size() > words_m) ? sent_q[words_m] : ~acc_m;
        chk("rand_word_m", acc_m, exp_w);
        words_m++;
      end
    end
    if (l_vld) begin
      acc_l = {l_seq, acc_l[BW-1:1]};
      n_l++;
      if (n_l == BW) begin
        n_l = 0;
        exp_w = (sent_q.size() > words_l) ? sent_q[words_l] : ~acc_l;
        chk("rand_word_l", acc_l, exp_w);
        words_l++;
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then
  // compare on the falling edge.
  task automatic cycle(input logic rstn, input logic valid, input logic [BW-1:0] data);
    i_rstn  = rstn;
    i_valid = valid;
    i_data  = data;
    @(posedge i_clk);
    model_update();
    @(negedge i_clk);
    cyc++;
    check_model();
    if (rec_en) reassemble();
  endtask

  typedef struct {
    logic          rstn;
    logic          valid;
    logic [BW-1:0] data;
    logic          seq_m;
    logic          seq_l;
    logic          vld;
    logic          done;
    logic          rdy;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int vld_cnt, busy_drop, ones, budget, sent;
    bit pending;
    logic [BW-1:0] pdata, w_m, w_l;

    // Reset for 4 cycles, then 8'hB4 through both bit orders.
    for (int i = 0; i < 4; i++) vecs[i] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 8'hB4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].rstn, vecs[i].valid, vecs[i].data);
      chk($sformatf("tbl%0d_seq_m", i), m_seq,   vecs[i].seq_m);
      chk($sformatf("tbl%0d_seq_l", i), l_seq,   vecs[i].seq_l);
      chk($sformatf("tbl%0d_vld", i),   m_vld,   vecs[i].vld);
      chk($sformatf("tbl%0d_done", i),  m_done,  vecs[i].done);
      chk($sformatf("tbl%0d_rdy", i),   m_ready, vecs[i].rdy);
    end

    // Back-to-back: 8'hB4, then 8'h3C held valid from cycle 1.
    vld_cnt = 0; busy_drop = 0; w_m = '0; w_l = '0;
    cycle(1'b1, 1'b1, 8'hB4);
    vld_cnt += int'(m_vld); busy_drop += int'(!m_busy);
    for (int k = 1; k <= 15; k++) begin
      cycle(1'b1, k <= 8, 8'h3C);
      vld_cnt += int'(m_vld); busy_drop += int'(!m_busy);
      if (k >= 8) begin
        w_m = {w_m[BW-2:0], m_seq};
        w_l = {l_seq, w_l[BW-1:1]};
      end
    end
    chk("b2b_vld_cycles", vld_cnt, 16);
    chk("b2b_busy_drops", busy_drop, 0);
    chk("b2b_word2_m", w_m, 8'h3C);
    chk("b2b_word2_l", w_l, 8'h3C);
    cycle(1'b1, 1'b0, 8'h00);
    chk("b2b_idle_after", m_vld, 1'b0);

    // 8'hFF offered mid-word and withdrawn before the last bit.
    ones = 0;
    cycle(1'b1, 1'b1, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, (k >= 3 && k <= 5), 8'hFF);
      ones += int'(m_seq) + int'(l_seq);
    end
    chk("ignored_ones", ones, 0);
    chk("ignored_idle_vld", m_vld, 1'b0);
    chk("ignored_idle_busy", m_busy, 1'b0);

    // Reset after three bits of 8'hFF; valid asserted during reset is ignored.
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    chk("rst_pre_seq", m_seq, 1'b1);
    cycle(1'b0, 1'b1, 8'hFF);
    chk("rst_seq", m_seq, 1'b0);
    chk("rst_vld", m_vld, 1'b0);
    ones = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b0, 8'h00);
      ones += int'(m_vld) + int'(l_vld);
    end
    chk("rst_ready", m_ready, 1'b1);
    chk("rst_residual", ones, 0);

    // Random words with random gaps; upstream holds a word until accepted.
    rec_en = 1'b1;
    pending = 1'b0; sent = 0; budget = 0; pdata = '0;
    while (!(sent == 100 && rem == 0) && budget < 5000) begin
      if (!pending) begin
        pdata = BW'($urandom);
        pending = (sent < 100) && ($urandom_range(0, 2) != 0);
      end
      cycle(1'b1, pending, pdata);
      if (last_xfer) begin
        sent_q.push_back(pdata);
        sent++;
        pending = 1'b0;
      end
      budget++;
    end
    cycle(1'b1, 1'b0, 8'h00);
    chk("rand_in_budget", budget < 5000, 1'b1);
    chk("rand_words_m", words_m, 100);
    chk("rand_words_l", words_l, 100);
    chk("rand_done_m", done_m, 100);
    chk("rand_done_l", done_l, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Upstream feeder for the serial sequence detector. Accepts parallel words over a valid/ready handshake and emits them one bit per clock on a serial line that drives the detector's sequence input.
- Supports gapless back-to-back streaming, so multi-word patterns spanning word boundaries reach the detector unbroken.
- Provides a last-bit pulse for bench scoreboarding.

Parameters:
- BW_DATA, 8, parallel word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit BW_DATA-1 is sent first; 0 = bit 0 is sent first.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rstn  input  1  reset; synchronous, active-low.
- i_data  input  BW_DATA  parallel word; sampled only on handshake.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  serializer can accept a word this cycle.
- o_seq  output  1  serial bit to detector (registered).
- o_seq_vld  output  1  o_seq carries a real data bit this cycle (registered).
- o_busy  output  1  high while in SHIFT (registered).
- o_word_done  output  1  high during the cycle o_seq carries the last bit of a word.

Behaviour:
- Reset: synchronous; i_rstn sampled low at a rising edge.
  - Result: state=IDLE, bit counter=0, shift register=0, o_seq=0, o_seq_vld=0, o_busy=0.
  - Derived outputs: o_ready=1 and o_word_done=0 from the first post-reset cycle.
- States: IDLE, SHIFT. Bit counter cnt has width $clog2(BW_DATA) and counts 0..BW_DATA-1.
- Handshake: a transfer occurs at a rising edge where i_valid=1 and o_ready=1. i_valid while o_ready=0 is ignored; the word is not captured, and upstream must hold it.
- o_ready is combinational from registers only, never from i_valid:
  - o_ready = (state==IDLE) || (state==SHIFT && cnt==BW_DATA-1).
- Latency: the first bit of the word appears on o_seq with o_seq_vld=1 in the cycle after the handshake edge.
  - Bits occupy exactly BW_DATA consecutive cycles in the order set by MSB_FIRST.
- Transitions:
  - IDLE + transfer -> SHIFT: load shift register, cnt=0.
  - IDLE, no transfer -> IDLE: o_seq=0, o_seq_vld=0.
  - SHIFT, cnt<BW_DATA-1 -> SHIFT: shift one position, cnt+1.
  - SHIFT, cnt==BW_DATA-1 + transfer -> SHIFT: reload, cnt=0, no bubble cycle.
  - SHIFT, cnt==BW_DATA-1, no transfer -> IDLE: o_seq returns to 0, o_seq_vld=0.
- o_word_done = o_seq_vld && cnt==BW_DATA-1; exactly one pulse per word.
- o_busy=1 exactly while state==SHIFT.
- Counter never wraps past BW_DATA-1; no illegal state is reachable. Default branch of the state decode returns to IDLE.
- Reset mid-word: the partial word is discarded and no further bits are emitted. o_seq_vld=0 the cycle after the reset edge. i_valid is ignored while i_rstn=0.
- o_seq is held 0 whenever o_seq_vld=0, so an idle line presents a constant 0 to the detector.

Test Plan:
- BW_DATA=8, MSB_FIRST=1; reset 4 cycles; send 8'hB4 -> o_seq = 1,0,1,1,0,1,0,0 on cycles 1..8 after handshake; o_seq_vld high 8 cycles; o_word_done only on cycle 8; o_ready low on cycles 1..7.
- MSB_FIRST=0; send 8'hB4 -> o_seq = 0,0,1,0,1,1,0,1; o_word_done on cycle 8.
- Back-to-back 8'hB4 then 8'h3C, second i_valid held from cycle 1 -> handshake at end of cycle 8; 16 consecutive o_seq_vld=1 cycles; second-word bits 0,0,1,1,1,1,0,0; o_busy never drops.
- i_valid=1 with 8'hFF asserted during cycle 3 of an 8'h00 word, then dropped before cycle 8 -> 8'hFF never emitted; o_seq stays 0 throughout; state returns to IDLE after cycle 8.
- Send 8'hFF, assert i_rstn=0 after 3 bits emitted -> o_seq=0 and o_seq_vld=0 from the next cycle; o_ready=1 after reset release; no residual bits emitted.
- 100 random words at random gaps, output fed to the detector -> serial stream reassembled by the bench equals the input words in order; o_word_done count equals 100.
